// File: rtl/varredor_load_aste_if.sv
// Bundle of the control/result handshake and the memory bus for the asteroid
// load scanner.
//   master : the scanner's view. It receives iniciar/modo_aloca/dado_aloca and mem_q,
//            and drives mem_addr/mem_we/mem_data plus the status/result outputs.
//   slave  : the environment's view, made up of game control and the 16x2 RAM.
interface varredor_load_aste_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
);
    logic              iniciar;
    logic              modo_aloca;
    logic [DATA_W-1:0] dado_aloca;
    logic [DATA_W-1:0] mem_q;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data;
    logic              ocupado;
    logic              pronto;
    logic              encontrado;
    logic [ADDR_W-1:0] endereco_livre;
    logic [ADDR_W:0]   contagem_ativos;

    modport master (
        input  iniciar, modo_aloca, dado_aloca, mem_q,
        output mem_addr, mem_we, mem_data, ocupado, pronto,
               encontrado, endereco_livre, contagem_ativos
    );

    modport slave (
        output iniciar, modo_aloca, dado_aloca, mem_q,
        input  mem_addr, mem_we, mem_data, ocupado, pronto,
               encontrado, endereco_livre, contagem_ativos
    );
endinterface

// File: rtl/varredor_load_aste.sv
// Reader/allocator master for the asteroid load memory (N_POS entries x DATA_W bits).
// When requested, it reads every entry in sequence, counts the non-zero slots and
// finds the lowest free (zero) slot. In allocate mode it then writes the
// latched load code into that slot.
// The RAM has a registered address, so mem_q returns the data for the
// address presented one cycle earlier. The scan therefore takes N_POS+1
// cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : varredor_load_aste_if.master, which carries the start request,
//           the memory bus and the results
module varredor_load_aste #(
    parameter int N_POS  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    varredor_load_aste_if.master  bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        VARRE   = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

    // idx counts scan cycles 0..N_POS. It needs one extra bit beyond the address.
    localparam logic [ADDR_W:0]   IDX_FIM   = (ADDR_W+1)'(N_POS);
    localparam logic [ADDR_W:0]   IDX_UM    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   IDX_ULT   = (ADDR_W+1)'(N_POS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ULT  = ADDR_W'(N_POS - 1);
    localparam logic [ADDR_W:0]   CONT_UM   = (ADDR_W+1)'(1);
    localparam logic [DATA_W-1:0] DADO_ZERO = {DATA_W{1'b0}};

    // A code of zero marks an empty slot.
    function automatic logic eh_livre(input logic [DATA_W-1:0] dado);
        return (dado == DADO_ZERO);
    endfunction

    estado_t           estado_q, estado_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic              modo_q, modo_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ocupado_q, ocupado_d;
    logic              pronto_q, pronto_d;
    logic              enc_q, enc_d;
    logic [ADDR_W-1:0] livre_q, livre_d;
    logic [ADDR_W:0]   cont_q, cont_d;

    // Next-state and registered-output logic for the scan/allocate sequence.
    always_comb begin
        estado_d  = estado_q;
        idx_d     = idx_q;
        modo_d    = modo_q;
        dado_d    = dado_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;
        enc_d     = enc_q;
        livre_d   = livre_q;
        cont_d    = cont_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    modo_d    = bus.modo_aloca;
                    dado_d    = bus.dado_aloca;
                    enc_d     = 1'b0;
                    livre_d   = {ADDR_W{1'b0}};
                    cont_d    = {(ADDR_W+1){1'b0}};
                    idx_d     = {(ADDR_W+1){1'b0}};
                    addr_d    = {ADDR_W{1'b0}};
                    ocupado_d = 1'b1;
                    estado_d  = VARRE;
                end else begin
                    estado_d  = OCIOSO;
                end
            end

            VARRE: begin
                // mem_q is valid from the second scan cycle onward. It holds address idx-1.
                if (idx_q != {(ADDR_W+1){1'b0}}) begin
                    if (!eh_livre(bus.mem_q)) begin
                        cont_d = cont_q + CONT_UM;
                    end else if (!enc_q) begin
                        livre_d = ADDR_W'(idx_q - IDX_UM);
                        enc_d   = 1'b1;
                    end else begin
                        livre_d = livre_q;
                    end
                end else begin
                    cont_d = cont_q;
                end

                if (idx_q == IDX_FIM) begin
                    // enc_d includes the final pipelined sample, which is address N_POS-1.
                    if (modo_q && enc_d) begin
                        estado_d = ESCREVE;
                        we_d     = 1'b1;
                        addr_d   = livre_d;
                        wdata_d  = dado_q;
                    end else begin
                        estado_d = FIM;
                        pronto_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IDX_UM;
                    // The address stops at the last entry during the drain cycle.
                    if (idx_q >= IDX_ULT) begin
                        addr_d = ADDR_ULT;
                    end else begin
                        addr_d = ADDR_W'(idx_q + IDX_UM);
                    end
                end
            end

            ESCREVE: begin
                if (!eh_livre(dado_q)) begin
                    cont_d = cont_q + CONT_UM;
                end else begin
                    cont_d = cont_q;
                end
                estado_d = FIM;
                pronto_d = 1'b1;
            end

            FIM: begin
                ocupado_d = 1'b0;
                estado_d  = OCIOSO;
            end

            default: begin
                ocupado_d = 1'b0;
                estado_d  = OCIOSO;
            end
        endcase
    end

    // State and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            idx_q     <= {(ADDR_W+1){1'b0}};
            modo_q    <= 1'b0;
            dado_q    <= {DATA_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            we_q      <= 1'b0;
            wdata_q   <= {DATA_W{1'b0}};
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            enc_q     <= 1'b0;
            livre_q   <= {ADDR_W{1'b0}};
            cont_q    <= {(ADDR_W+1){1'b0}};
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            modo_q    <= modo_d;
            dado_q    <= dado_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            enc_q     <= enc_d;
            livre_q   <= livre_d;
            cont_q    <= cont_d;
        end
    end

    assign bus.mem_addr        = addr_q;
    assign bus.mem_we          = we_q;
    assign bus.mem_data        = wdata_q;
    assign bus.ocupado         = ocupado_q;
    assign bus.pronto          = pronto_q;
    assign bus.encontrado      = enc_q;
    assign bus.endereco_livre  = livre_q;
    assign bus.contagem_ativos = cont_q;

endmodule

// File: tb/tb_varredor_load_aste.sv
// Self-checking bench for varredor_load_aste. It contains a registered-address
// 16x2 RAM model, a table of scan/allocate vectors with a scoreboard queue, and
// hand-written sequences for the held-start and reset corner cases.
module tb_varredor_load_aste;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    varredor_load_aste_if #(.ADDR_W(4), .DATA_W(2)) bus ();

    varredor_load_aste #(.N_POS(16), .ADDR_W(4), .DATA_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: the address is registered, q comes one cycle later, and reads happen before writes.
    logic [1:0]  mem [16];
    logic [1:0]  mem_q_r;
    logic        load_req;
    logic [31:0] load_img;
    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < 16; k++) mem[k] <= load_img[2*k +: 2];
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_data;
        end
        mem_q_r <= mem[bus.mem_addr];
    end
    assign bus.mem_q = mem_q_r;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nome, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, act, exp);
        end
    endtask

    typedef struct {
        bit          carrega;
        logic [31:0] img;
        logic        modo;
        logic [1:0]  dado;
        logic        enc;
        logic [3:0]  livre;
        logic [4:0]  cont;
        logic        escreve;
        int          lat;
    } vec_t;

    typedef struct {
        logic       enc;
        logic [3:0] livre;
        logic [4:0] cont;
        logic       escreve;
        logic [3:0] w_addr;
        logic [1:0] w_data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[7];

    task automatic carregar(input logic [31:0] img);
        @(negedge clk);
        load_img = img;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nome);
        check(nome, int'({bus.mem_addr, bus.mem_we, bus.mem_data, bus.ocupado, bus.pronto,
                          bus.encontrado, bus.endereco_livre, bus.contagem_ativos}), 0);
    endtask

    // Runs one operation and compares its results with the front of the scoreboard.
    task automatic run_op(input logic modo, input logic [1:0] dado);
        int cyc_pronto = 0;
        int n_we = 0;
        int we_cyc = 0;
        logic [3:0] wa = 4'd0;
        logic [1:0] wd = 2'd0;
        bit addr_ok = 1'b1;
        bit ocup_ok = 1'b1;
        logic [3:0] ea;
        exp_t e;
        @(negedge clk);
        bus.iniciar    = 1'b1;
        bus.modo_aloca = modo;
        bus.dado_aloca = dado;
        @(posedge clk);
        for (int c = 1; c <= 40 && cyc_pronto == 0; c++) begin
            @(negedge clk);
            if (c == 1) bus.iniciar = 1'b0;
            ea = (c > 16) ? 4'd15 : 4'(c - 1);
            if (c <= 17 && bus.mem_addr != ea) addr_ok = 1'b0;
            if (!bus.ocupado) ocup_ok = 1'b0;
            if (bus.mem_we) begin
                n_we++;
                we_cyc = c;
                wa = bus.mem_addr;
                wd = bus.mem_data;
            end
            if (bus.pronto) cyc_pronto = c;
        end
        check("pronto_timeout", int'(cyc_pronto != 0), 1);
        if (sb.size() == 0) begin
            check("scoreboard_vazio", 0, 1);
        end else begin
            e = sb.pop_front();
            check("latencia_pronto", cyc_pronto, e.lat);
            check("seq_mem_addr", int'(addr_ok), 1);
            check("ocupado_ate_pronto", int'(ocup_ok), 1);
            check("num_escritas", n_we, e.escreve ? 1 : 0);
            if (e.escreve) begin
                check("ciclo_escrita", we_cyc, 18);
                check("addr_escrita", int'(wa), int'(e.w_addr));
                check("dado_escrita", int'(wd), int'(e.w_data));
            end
            check("encontrado", int'(bus.encontrado), int'(e.enc));
            check("endereco_livre", int'(bus.endereco_livre), int'(e.livre));
            check("contagem_ativos", int'(bus.contagem_ativos), int'(e.cont));
        end
        @(negedge clk);
        check("ocupado_apos_pronto", int'({bus.ocupado, bus.pronto}), 0);
        check("resultado_mantido", int'(bus.contagem_ativos), int'(e.cont));
    endtask

    // Asserts reset during cycle 'ciclo' of an allocate operation, then checks the recovery.
    task automatic reset_em(input int ciclo, input bit checar_mem, input string nome);
        int n_we = 0;
        carregar(32'h0000_0E79);
        @(negedge clk);
        bus.iniciar    = 1'b1;
        bus.modo_aloca = 1'b1;
        bus.dado_aloca = 2'b01;
        @(posedge clk);
        for (int c = 1; c <= ciclo; c++) begin
            @(negedge clk);
            if (c == 1) bus.iniciar = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs({nome, "_saidas"});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_we || bus.ocupado || bus.pronto) n_we++;
        end
        check({nome, "_ocioso_sem_escrita"}, n_we, 0);
        if (checar_mem) check({nome, "_memoria_intacta"}, int'(mem[6]), 0);
    endtask

    initial begin
        exp_t e;
        int np;
        int cp;
        logic o19;
        logic o20;
        reset = 1'b1;
        bus.iniciar = 1'b0;
        bus.modo_aloca = 1'b0;
        bus.dado_aloca = 2'b00;
        load_req = 1'b0;
        load_img = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("estado_reset");
        reset = 1'b0;

        vt[0] = '{1'b1, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 4'd0,  5'd0,  1'b0, 18};
        vt[1] = '{1'b1, 32'h0000_0E79, 1'b1, 2'b10, 1'b1, 4'd6,  5'd7,  1'b1, 19};
        vt[2] = '{1'b0, 32'h0000_0000, 1'b0, 2'b00, 1'b1, 4'd7,  5'd7,  1'b0, 18};
        vt[3] = '{1'b1, 32'h5555_5555, 1'b1, 2'b11, 1'b0, 4'd0,  5'd16, 1'b0, 18};
        vt[4] = '{1'b1, 32'h3FFF_FFFF, 1'b1, 2'b01, 1'b1, 4'd15, 5'd16, 1'b1, 19};
        vt[5] = '{1'b1, 32'h0000_003F, 1'b1, 2'b00, 1'b1, 4'd3,  5'd3,  1'b1, 19};
        vt[6] = '{1'b1, 32'h5555_5455, 1'b0, 2'b00, 1'b1, 4'd4,  5'd15, 1'b0, 18};

        for (int i = 0; i < 7; i++) begin
            if (vt[i].carrega) carregar(vt[i].img);
            e.enc     = vt[i].enc;
            e.livre   = vt[i].livre;
            e.cont    = vt[i].cont;
            e.escreve = vt[i].escreve;
            e.w_addr  = vt[i].livre;
            e.w_data  = vt[i].dado;
            e.lat     = vt[i].lat;
            sb.push_back(e);
            run_op(vt[i].modo, vt[i].dado);
        end

        // iniciar held high: one operation, then a restart only after FIM.
        carregar(32'h0000_0000);
        np = 0; cp = 0; o19 = 1'b0; o20 = 1'b0;
        @(negedge clk);
        bus.iniciar = 1'b1;
        bus.modo_aloca = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.pronto) begin np++; cp = c; end
            if (c == 19) o19 = bus.ocupado;
            if (c == 20) o20 = bus.ocupado;
        end
        bus.iniciar = 1'b0;
        check("hold_pulsos_pronto", np, 1);
        check("hold_ciclo_pronto", cp, 18);
        check("hold_ocioso_apos_fim", int'(o19), 0);
        check("hold_reinicio", int'(o20), 1);
        cp = 0;
        for (int c = 21; c <= 60 && cp == 0; c++) begin
            @(negedge clk);
            if (bus.pronto) cp = c;
        end
        check("hold_segundo_pronto", cp, 37);

        reset_em(10, 1'b1, "reset_varre");
        reset_em(17, 1'b1, "reset_entrada_escreve");
        reset_em(18, 1'b0, "reset_escreve");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
